mac_seq_ctrl: RTL and testbench

//  Sequencer for the 4-lane MAC datapath (mac_wrapper: unsigned x, signed w, psum feedback c).

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_opnd_reg.sv | 36 +++
 rtl/mac_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module : mac_pkg
// Brief  : Shared constants and sequencer state encoding for the MAC datapath.
// Rev    : 1.0  initial release
// ============================================================================
package mac_pkg;

    localparam int LANES       = 4;
    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_opnd_reg.sv
`default_nettype none
// ============================================================================
// Module : mac_opnd_reg
// Brief  : Load-enabled register pair holding one packed x/w operand group.
// Rev    : 1.0  initial release
// ============================================================================
module mac_opnd_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_w,
    output logic [W-1:0] o_x,
    output logic [W-1:0] o_w
);

    logic [W-1:0] r_x;
    logic [W-1:0] r_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_w <= '0;
        end else if (i_load) begin
            r_x <= i_x;
            r_w <= i_w;
        end
    end

    assign o_x = r_x;
    assign o_w = r_w;

endmodule : mac_opnd_reg
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mac_seq_ctrl
// Brief  : Job sequencer feeding operand groups to mac_wrapper and
//          accumulating the returned psum into a single result.
// Rev    : 1.0  initial release
// ============================================================================
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int BW      = BW_DEF,
    parameter int PSUM_BW = PSUM_BW_DEF,
    parameter int LEN_BW  = 8,
    parameter int MAC_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_BW-1:0]     len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*BW-1:0]   in_x,
    input  logic [LANES*BW-1:0]   in_w,
    output logic [LANES*BW-1:0]   mac_x,
    output logic [LANES*BW-1:0]   mac_w,
    output logic [PSUM_BW-1:0]    mac_c,
    input  logic [PSUM_BW-1:0]    mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PSUM_BW-1:0]    res_data
);

    localparam int c_WCNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(MAC_LAT);
    localparam logic [LEN_BW-1:0]   c_LEN_ONE   = LEN_BW'(1);

    mac_state_t          r_state;
    mac_state_t          w_next;
    logic [PSUM_BW-1:0]  r_acc;
    logic [LEN_BW-1:0]   r_remaining;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                w_load;
    logic                w_last_wait;

    assign w_load      = (r_state == ST_FETCH) && in_valid;
    assign w_last_wait = (r_state == ST_WAIT) && (r_wcnt == c_WCNT_LAST);

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (len != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_last_wait) begin
                    w_next = (r_remaining > c_LEN_ONE) ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // WAIT spans MAC_LAT+1 edges so mac_out reflects the held operands at the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_wcnt      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_remaining <= len;
                    end
                end
                ST_FETCH: begin
                    if (in_valid) begin
                        r_wcnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_last_wait) begin
                        r_acc       <= mac_out;
                        r_remaining <= r_remaining - c_LEN_ONE;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mac_opnd_reg #(
        .W (LANES*BW)
    ) u_opnd_reg (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load),
        .i_x    (in_x),
        .i_w    (in_w),
        .o_x    (mac_x),
        .o_w    (mac_w)
    );

    assign mac_c    = r_acc;
    assign res_data = r_acc;

endmodule : mac_seq_ctrl
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_mac_seq_ctrl
// Brief  : Directed self-checking bench for mac_seq_ctrl with a behavioural
//          mac_wrapper stand-in (registered, MAC_LAT stages).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mac_seq_ctrl;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LEN_BW  = 8;
    localparam int MAC_LAT = 1;
    localparam int W       = 4*BW;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [LEN_BW-1:0]  len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_x;
    logic [W-1:0]       in_w;
    logic [W-1:0]       mac_x;
    logic [W-1:0]       mac_w;
    logic [PSUM_BW-1:0] mac_c;
    logic [PSUM_BW-1:0] mac_out;
    logic               res_valid;
    logic               res_ready;
    logic [PSUM_BW-1:0] res_data;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW),
        .LEN_BW  (LEN_BW),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    // mac_wrapper stand-in: out = c + sum(x_i * sext(w_i)), MAC_LAT register stages
    function automatic logic [PSUM_BW-1:0] mac_f(input logic [W-1:0] x,
                                                 input logic [W-1:0] w,
                                                 input logic [PSUM_BW-1:0] c);
        int s;
        s = int'(c);
        for (int i = 0; i < 4; i++) begin
            s += int'(x[i*BW +: BW]) * int'($signed(w[i*BW +: BW]));
        end
        return s[PSUM_BW-1:0];
    endfunction

    logic [PSUM_BW-1:0] r_pipe [MAC_LAT];
    always @(posedge clk) begin
        r_pipe[0] <= mac_f(mac_x, mac_w, mac_c);
        for (int i = 1; i < MAC_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign mac_out = r_pipe[MAC_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one group and return at the negedge after it was accepted.
    task automatic send_group(input logic [W-1:0] x, input logic [W-1:0] w);
        in_x     = x;
        in_w     = w;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        chk("in_ready_seen", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [PSUM_BW-1:0] exp);
        for (int k = 0; k < 50 && !res_valid; k++) @(negedge clk);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_data"}, 32'(res_data), 32'(exp));
        res_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_mac_x", 32'(mac_x), 32'd0);
        chk("rst_mac_w", 32'(mac_w), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: len=2, all-ones operands, in_valid held high; latency and sum
        in_x = 16'h1111; in_w = 16'h1111; in_valid = 1'b1;
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        cnt = 1;
        while (!res_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("t1_latency", 32'(cnt), 32'(2*(MAC_LAT+2)+1));
        in_valid = 1'b0;
        wait_result("t1", 16'd8);

        // 2: x=15, w=-8 on all lanes
        start = 1'b1; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        send_group(16'hFFFF, 16'h8888);
        wait_result("t2", 16'hFE20);

        // 3: len=3 with a 5-cycle stall before group 2
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        send_group(16'h4321, 16'h1111);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_ready", 32'(in_ready), 32'd1);
            chk("t3_stall_x", 32'(mac_x), 32'h4321);
            chk("t3_stall_w", 32'(mac_w), 32'h1111);
            @(negedge clk);
        end
        send_group(16'h5555, 16'hFFFF);
        send_group(16'hFFFF, 16'h7777);
        wait_result("t3", 16'h019A);

        // 4: len=0 goes straight to DONE; result held while res_ready low
        res_ready = 1'b0;
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_res_valid", 32'(res_valid), 32'd1);
            chk("t4_res_data", 32'(res_data), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_valid", 32'(res_valid), 32'd0);

        // 5: start pulsed during WAIT of job A is ignored
        in_x = 16'h3333; in_w = 16'h2222; in_valid = 1'b1;
        start = 1'b1; len = 8'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_in_wait", 32'(in_ready), 32'd0);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_result("t5", 16'd48);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_restart", 32'(busy), 32'd0);

        // 6: reset during WAIT of a len=4 job, then a clean len=1 job
        in_x = 16'h1111; in_w = 16'h1111; in_valid = 1'b1;
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_mac_c", 32'(mac_c), 32'd4);
        chk("t6_in_wait", 32'(in_ready), 32'd0);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_acc", 32'(res_data), 32'd0);
        chk("t6_mac_x", 32'(mac_x), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_result", 32'(res_valid), 32'd0);
        start = 1'b1; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        send_group(16'h7777, 16'hDDDD);
        wait_result("t6", 16'hFFAC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_seq_ctrl
`default_nettype wire
